// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, signed or unsigned.
// Magnitudes are multiplied over WIDTH cycles; the sign is applied once in a final fix-up cycle.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH:0]     upper_sum;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic            is_signed);
    return (is_signed && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic              negate);
    return negate ? (~mag + (2*WIDTH)'(1)) : mag;
  endfunction

  // One shift-add step: the top bit is always clear before the add, so the carry fits.
  always_comb begin
    upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    acc_d     = acc_q[0] ? {1'b0, upper_sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= magnitude(a, signed_op);
            acc_q   <= {{(WIDTH+1){1'b0}}, magnitude(b, signed_op)};
            neg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= FIX;
        end
        FIX: begin
          // Busy drops with done so a start held in the done cycle is taken next edge.
          product_q <= apply_sign(acc_q[2*WIDTH-1:0], neg_q);
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: timeline reference model checked every cycle,
// directed corner cases with literal products, then randomized traffic.
module tb_seq_multiplier;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic           clk       = 1'b0;
  logic           reset     = 1'b0;
  logic           start     = 1'b0;
  logic           signed_op = 1'b0;
  logic [W-1:0]   a         = '0;
  logic [W-1:0]   b         = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_vec = 0;
  int n_err = 0;

  logic           m_active = 1'b0;
  logic           m_busy   = 1'b0;
  logic           m_done   = 1'b0;
  logic [2*W-1:0] m_prod   = '0;
  logic [2*W-1:0] m_res    = '0;
  int             m_k      = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .signed_op(signed_op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return 64'(ux * uy);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Reference: an accepted start produces its result LAT edges later; start is
  // only accepted when no operation is outstanding.
  always @(posedge clk) begin
    if (!reset) begin
      m_active = 1'b0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_prod   = '0;
      m_k      = 0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_busy   = 1'b1;
          m_k      = 0;
          m_res    = ref_mul(a, b, signed_op);
        end
      end else begin
        m_k++;
        if (m_k == LAT) begin
          m_prod   = m_res;
          m_done   = 1'b1;
          m_busy   = 1'b0;
          m_active = 1'b0;
        end
      end
    end
    #1;
    check("model_busy", 64'(busy), 64'(m_busy));
    check("model_done", 64'(done), 64'(m_done));
    check("model_product", product, m_prod);
  end

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) return;
    end
    n = -1;
  endtask

  task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       input logic [63:0] exp_lit, input string nm);
    int n;
    @(negedge clk);
    a = ia; b = ib; signed_op = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_after_start"}, 64'(busy), 64'd1);
    wait_done(n);
    check({nm, "_latency"}, 64'(n), 64'(LAT));
    check({nm, "_product"}, product, exp_lit);
    check({nm, "_busy_in_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    do_op(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, "u3x5");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
    @(posedge clk);
    #1;
    check("umax_done_drops", 64'(done), 64'd0);
    check("umax_product_holds", product, 64'hFFFF_FFFE_0000_0001);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "s_m1x1");
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minxmin");
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000, "s_minx1");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s_m1xm1");

    // Start while busy is ignored; start held in the done cycle is accepted.
    @(negedge clk);
    a = 32'd7; b = 32'd6; signed_op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("busy_ign_latency", 64'(n), 64'(LAT - 10));
    check("busy_ign_product", product, 64'd42);
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("b2b_latency", 64'(n), 64'(LAT));
    check("b2b_product", product, 64'd4);

    // Abort mid-operation.
    @(negedge clk);
    a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_result", product, 64'd0);
    do_op(32'd4, 32'd4, 1'b0, 64'd16, "post_rst");

    // Randomized traffic; the reference model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start     = ($urandom_range(3) == 0);
      a         = pick();
      b         = pick();
      signed_op = 1'($urandom_range(1));
      reset     = !($urandom_range(299) == 0);
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
